// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Round-robin scheduler that shares one external combinational adder between
//   NREQ requesters. One requester is granted per cycle; its operands are driven
//   onto the adder and the adder result is captured in a single-entry response
//   register, returned with the requester ID over a valid/ready handshake.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready     per-requester handshake (req_ready one-hot or zero)
//   req_a/req_b             packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin                 per-requester carry-in
//   req_sub                 per-requester subtract select (ADDER_ARBITER_SUB_EN only)
//   add_a/add_b/add_cin     operands to the shared adder (zero when idle)
//   add_sum/add_cout        result from the shared adder, sampled the same cycle
//   rsp_valid/rsp_ready     response handshake
//   rsp_id/rsp_sum/rsp_cout registered response fields
//
// Build option:
//   ADDER_ARBITER_SUB_EN    adds req_sub; a granted subtract drives ~B with cin=1
//                           so the result is A-B (rsp_cout=1 means no borrow).

module adder_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
`ifdef ADDER_ARBITER_SUB_EN
    input  logic [NREQ-1:0]       req_sub,
`endif
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_ptr;
    logic             r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic [WIDTH-1:0] r_rsp_sum;
    logic             r_rsp_cout;

    logic             w_can_issue;
    logic             w_grant;
    logic [IDW-1:0]   w_gnt;
    logic [IDW-1:0]   w_ptr_next;
    logic [WIDTH-1:0] w_a [NREQ];
    logic [WIDTH-1:0] w_b [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_a[gi] = req_a[gi*WIDTH +: WIDTH];
        assign w_b[gi] = req_b[gi*WIDTH +: WIDTH];
    end

    // rst_n gates issue so req_ready stays low for the whole reset window.
    assign w_can_issue = rst_n & ((r_state == S_EMPTY) | (r_rsp_valid & rsp_ready));

    // First valid requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin : grant_search
        logic [IDW:0]   w_idx;
        logic [IDW-1:0] w_cand;
        w_grant = 1'b0;
        w_gnt   = '0;
        w_idx   = '0;
        w_cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NREQ)) begin
                w_idx = w_idx - (IDW+1)'(NREQ);
            end
            w_cand = w_idx[IDW-1:0];
            if (!w_grant && w_can_issue && req_valid[w_cand]) begin
                w_grant = 1'b1;
                w_gnt   = w_cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_gnt] = 1'b1;
        end
    end

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (w_grant) begin
            add_a = w_a[w_gnt];
`ifdef ADDER_ARBITER_SUB_EN
            if (req_sub[w_gnt]) begin
                add_b   = ~w_b[w_gnt];
                add_cin = 1'b1;
            end else begin
                add_b   = w_b[w_gnt];
                add_cin = req_cin[w_gnt];
            end
`else
            add_b   = w_b[w_gnt];
            add_cin = req_cin[w_gnt];
`endif
        end
    end

    assign w_ptr_next = (w_gnt == IDW'(NREQ-1)) ? '0 : w_gnt + 1'b1;

    // A grant already implies the response slot is free or being drained,
    // so a grant always captures; FULL only empties on a drain with no grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_ptr       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_grant) begin
                        r_state     <= S_FULL;
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= w_gnt;
                        r_rsp_sum   <= add_sum;
                        r_rsp_cout  <= add_cout;
                        r_ptr       <= w_ptr_next;
                    end
                end
                S_FULL: begin
                    if (w_grant) begin
                        r_rsp_id    <= w_gnt;
                        r_rsp_sum   <= add_sum;
                        r_rsp_cout  <= add_cout;
                        r_ptr       <= w_ptr_next;
                    end else if (rsp_ready) begin
                        r_state     <= S_EMPTY;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_cout  = r_rsp_cout;

endmodule

// File: tb/tb_adder_arbiter.sv
// Testbench for adder_arbiter: the shared adder is modelled behaviourally, the
// stimulus pushes hand-computed responses into a queue and a monitor pops and
// compares them whenever the DUT hands a response over.

module tb_adder_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
`ifdef ADDER_ARBITER_SUB_EN
    logic [NREQ-1:0]       req_sub;
`endif
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic                  add_cin;
    logic [WIDTH-1:0]      add_sum;
    logic                  add_cout;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;

    always #5 clk = ~clk;

    // Shared combinational adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    adder_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .IDW   (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
`ifdef ADDER_ARBITER_SUB_EN
        .req_sub   (req_sub),
`endif
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } rsp_t;

    rsp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [IDW-1:0] id, input logic [WIDTH-1:0] sum, input logic cout);
        rsp_t e;
        e.id   = id;
        e.sum  = sum;
        e.cout = cout;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_cin[i]              = cin;
    endtask

    // Inputs change 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Monitor: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            rsp_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id=%0d sum=0x%0h cout=%0d expected none",
                         rsp_id, rsp_sum, rsp_cout);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_id",   64'(rsp_id),   64'(e.id));
                chk("rsp_sum",  64'(rsp_sum),  64'(e.sum));
                chk("rsp_cout", 64'(rsp_cout), 64'(e.cout));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

    rsp_t            rr_exp   [5];
    logic [NREQ-1:0] rr_ready [5];

    initial begin
        rr_exp[0] = '{id: 2'd0, sum: 32'h0000_0100, cout: 1'b0};
        rr_exp[1] = '{id: 2'd1, sum: 32'h0000_0201, cout: 1'b0};
        rr_exp[2] = '{id: 2'd2, sum: 32'h0000_0302, cout: 1'b0};
        rr_exp[3] = '{id: 2'd3, sum: 32'h0000_0403, cout: 1'b0};
        rr_exp[4] = '{id: 2'd0, sum: 32'h0000_0100, cout: 1'b0};
        rr_ready[0] = 4'b0001;
        rr_ready[1] = 4'b0010;
        rr_ready[2] = 4'b0100;
        rr_ready[3] = 4'b1000;
        rr_ready[4] = 4'b0001;

        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b0;
`ifdef ADDER_ARBITER_SUB_EN
        req_sub   = '0;
`endif
        #12;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_id",    64'(rsp_id),    64'd0);
        chk("reset_rsp_sum",   64'(rsp_sum),   64'd0);
        chk("reset_rsp_cout",  64'(rsp_cout),  64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
        step();

        // Round-robin with every requester valid.
        set_req(0, 32'h0000_0100, 32'd0, 1'b0);
        set_req(1, 32'h0000_0200, 32'd1, 1'b0);
        set_req(2, 32'h0000_0300, 32'd2, 1'b0);
        set_req(3, 32'h0000_0400, 32'd3, 1'b0);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_req_ready", 64'(req_ready), 64'(rr_ready[k]));
            if (k > 0) chk("rr_rsp_valid", 64'(rsp_valid), 64'd1);
            push(rr_exp[k].id, rr_exp[k].sum, rr_exp[k].cout);
            step();
        end
        req_valid = '0;
        step();
        chk("drain_rsp_valid", 64'(rsp_valid), 64'd0);

        // Single request (pointer is 1, search wraps to requester 0).
        set_req(0, 32'h0000_0005, 32'h0000_0003, 1'b1);
        req_valid = 4'b0001;
        #1;
        chk("single_req_ready", 64'(req_ready), 64'b0001);
        push(2'd0, 32'h0000_0009, 1'b0);
        step();
        chk("single_latency_valid", 64'(rsp_valid), 64'd1);
        req_valid = '0;
        step();

        // Carry out of the top bit.
        set_req(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        req_valid = 4'b0001;
        #1;
        chk("wrap_req_ready", 64'(req_ready), 64'b0001);
        push(2'd0, 32'h0000_0000, 1'b1);
        step();
        req_valid = '0;
        step();

        // Backpressure: 0x10 pending while req1/req2 wait.
        set_req(0, 32'h0000_000C, 32'h0000_0004, 1'b0);
        set_req(1, 32'h0000_0020, 32'h0000_0001, 1'b1);
        set_req(2, 32'h0000_0030, 32'h0000_0000, 1'b0);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        chk("bp_issue_ready", 64'(req_ready), 64'b0001);
        push(2'd0, 32'h0000_0010, 1'b0);
        step();
        req_valid = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_sum",   64'(rsp_sum),   64'h10);
            chk("bp_rsp_id",    64'(rsp_id),    64'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(req_ready), 64'b0010);
        push(2'd1, 32'h0000_0022, 1'b0);
        step();
        req_valid = '0;
        rsp_ready = 1'b0;
        #1;
        chk("bp_replaced_id", 64'(rsp_id), 64'd1);

        // Reset mid-operation with pointer at 2 and a response pending.
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_rsp_sum",   64'(rsp_sum),   64'd0);
        chk("midrst_rsp_id",    64'(rsp_id),    64'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        set_req(1, 32'h0000_0007, 32'h0000_0008, 1'b0);
        set_req(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        req_valid = 4'b1010;
        rsp_ready = 1'b1;
        #1;
        chk("postrst_ready_req1", 64'(req_ready), 64'b0010);
        push(2'd1, 32'h0000_000F, 1'b0);
        step();
        req_valid = 4'b1000;
        #1;
        chk("postrst_ready_req3", 64'(req_ready), 64'b1000);
        push(2'd3, 32'hFFFF_FFFF, 1'b1);
        step();
        req_valid = '0;
        step();
        step();

`ifdef ADDER_ARBITER_SUB_EN
        // Subtract: cin deliberately 0 to show it is forced to 1.
        req_sub[0] = 1'b1;
        set_req(0, 32'd3, 32'd5, 1'b0);
        req_valid  = 4'b0001;
        #1;
        chk("sub_req_ready", 64'(req_ready), 64'b0001);
        push(2'd0, 32'hFFFF_FFFE, 1'b0);
        step();
        set_req(0, 32'd5, 32'd3, 1'b0);
        push(2'd0, 32'h0000_0002, 1'b1);
        step();
        req_valid  = '0;
        req_sub    = '0;
        step();
        step();
`endif

        step();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
